xfer_req_mux: RTL and testbench



---
 rtl/xfer_req_mux.sv | 171 +++++++++++++++++
 tb/tb_xfer_req_mux.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfer_req_mux.sv
// Multi-channel transfer-request multiplexer: per-channel FIFOs, round-robin
// arbitration and optional splitting of long requests into MAX_BURST bursts.
module xfer_req_mux #(
  parameter int NUM_CH     = 4,
  parameter int LEN_W      = 4,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*LEN_W-1:0]    in_length,
  input  logic [NUM_CH*ADDR_W-1:0]   in_source,
  input  logic [NUM_CH*ADDR_W-1:0]   in_destination,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LEN_W-1:0]           out_length,
  output logic [ADDR_W-1:0]          out_source,
  output logic [ADDR_W-1:0]          out_destination,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_last,
  output logic [7:0]                 drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = LEN_W + 2 * ADDR_W;
  localparam int SUM_W = 9 + $clog2(NUM_CH + 1);
  localparam logic [LEN_W-1:0]  BURST_LEN  = LEN_W'(MAX_BURST);
  localparam logic [ADDR_W-1:0] BURST_ADDR = ADDR_W'(MAX_BURST);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  logic [NUM_CH-1:0] full, not_empty, push, pop, drop;
  logic [ENT_W-1:0]  head [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
      logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
      logic [PTR_W:0]   cnt_q;
      logic [LEN_W-1:0] len_in;

      assign len_in        = in_length[gi*LEN_W +: LEN_W];
      assign full[gi]      = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
      assign not_empty[gi] = (cnt_q != '0);
      assign in_ready[gi]  = ~full[gi];
      // Zero-length requests complete the handshake but never reach the FIFO.
      assign push[gi]      = in_valid[gi] & ~full[gi] & (len_in != '0);
      assign drop[gi]      = in_valid[gi] & ~full[gi] & (len_in == '0);
      assign head[gi]      = mem_q[rd_ptr_q];

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_q[wr_ptr_q] <= {len_in, in_source[gi*ADDR_W +: ADDR_W],
                              in_destination[gi*ADDR_W +: ADDR_W]};
        end
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          if (push[gi]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (pop[gi])  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          case ({push[gi], pop[gi]})
            2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
            default: cnt_q <= cnt_q;
          endcase
        end
      end
    end
  endgenerate

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [CH_W-1:0]   ch_q, ch_d, last_grant_q, last_grant_d, grant_ch, idx;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [SUM_W-1:0]  drop_sum;
  logic              grant_found, burst_last, fire, load;

  // Round-robin search starting just after the previously loaded channel.
  always_comb begin
    grant_ch    = last_grant_q;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant_q) + k) % NUM_CH);
      if (!grant_found && not_empty[idx]) begin
        grant_found = 1'b1;
        grant_ch    = idx;
      end
    end
  end

  always_comb begin
    drop_sum = SUM_W'(drop_cnt_q);
    for (int k = 0; k < NUM_CH; k++) begin
      drop_sum = drop_sum + SUM_W'(drop[k]);
    end
    drop_cnt_d = (drop_sum > SUM_W'(255)) ? 8'hFF : drop_sum[7:0];
  end

  assign burst_last = (MAX_BURST == 0) || (rem_q <= BURST_LEN);
  assign fire       = (state_q == ISSUE) && out_ready;
  assign load       = grant_found && ((state_q == IDLE) || (fire && burst_last));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      ch_q         <= '0;
      last_grant_q <= LAST_CH;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      ch_q         <= ch_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    src_d        = src_q;
    dst_d        = dst_q;
    ch_d         = ch_q;
    last_grant_d = last_grant_q;
    pop          = '0;
    if (load) begin
      state_d                = ISSUE;
      {rem_d, src_d, dst_d}  = head[grant_ch];
      ch_d                   = grant_ch;
      last_grant_d           = grant_ch;
      pop[grant_ch]          = 1'b1;
    end else if (fire) begin
      if (burst_last) begin
        state_d = IDLE;
      end else begin
        rem_d = rem_q - BURST_LEN;
        src_d = src_q + BURST_ADDR;
        dst_d = dst_q + BURST_ADDR;
      end
    end
  end

  always_comb begin
    out_valid       = (state_q == ISSUE);
    out_last        = (state_q == ISSUE) && burst_last;
    out_length      = '0;
    if (state_q == ISSUE) out_length = burst_last ? rem_q : BURST_LEN;
    out_source      = src_q;
    out_destination = dst_q;
    out_ch          = ch_q;
    drop_cnt        = drop_cnt_q;
  end

endmodule

// File: tb/tb_xfer_req_mux.sv
// Bench for xfer_req_mux: directed table, hand-written corner sequences and
// random traffic checked against a transaction-level queue model.
module tb_xfer_req_mux;
  localparam int NUM_CH = 4, LEN_W = 4, ADDR_W = 8, FIFO_DEPTH = 4, MAX_BURST = 4;
  localparam int CH_W = 2;

  logic                     clk = 1'b0;
  logic                     nrst = 1'b0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*LEN_W-1:0]  in_length = '0;
  logic [NUM_CH*ADDR_W-1:0] in_source = '0;
  logic [NUM_CH*ADDR_W-1:0] in_destination = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [LEN_W-1:0]         out_length;
  logic [ADDR_W-1:0]        out_source, out_destination;
  logic [CH_W-1:0]          out_ch;
  logic                     out_last;
  logic [7:0]               drop_cnt;

  xfer_req_mux #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .ADDR_W(ADDR_W),
                 .FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_length(in_length), .in_source(in_source), .in_destination(in_destination),
    .out_valid(out_valid), .out_ready(out_ready), .out_length(out_length),
    .out_source(out_source), .out_destination(out_destination), .out_ch(out_ch),
    .out_last(out_last), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  typedef struct { int len; int src; int dst; } req_t;
  typedef struct { int ch; int len; int src; int dst; int last; int cyc; } burst_t;
  typedef struct { int ch; int len; int src; int dst; int n; int first_len;
                   int last_len; int last_src; int last_dst; int drops; } vec_t;

  int     errors = 0, checks = 0, cyc = 0;
  req_t   mq [NUM_CH][$];
  burst_t cap [$];
  bit     act = 0;
  int     a_ch, a_rem, a_src, a_dst, drop_model = 0, mon_len;
  req_t   mon_r;
  burst_t mon_b;
  vec_t   tbl [8];

  task automatic check(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  always @(posedge clk) cyc++;

  // Transaction-level reference: requests queue per channel, a request is
  // consumed as consecutive bursts of at most MAX_BURST from one channel.
  always @(negedge clk) begin
    if (!nrst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      act = 0;
      drop_model = 0;
      cap.delete();
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_valid[c] && in_ready[c]) begin
          mon_len = int'(in_length[c*LEN_W +: LEN_W]);
          if (mon_len == 0) drop_model = (drop_model < 255) ? drop_model + 1 : 255;
          else mq[c].push_back('{mon_len, int'(in_source[c*ADDR_W +: ADDR_W]),
                                 int'(in_destination[c*ADDR_W +: ADDR_W])});
        end
      end
      if (out_valid && out_ready) begin
        mon_b = '{int'(out_ch), int'(out_length), int'(out_source),
                  int'(out_destination), int'(out_last), cyc};
        cap.push_back(mon_b);
        if (!act) begin
          check("mon_pending", int'(mq[mon_b.ch].size() > 0), 1);
          if (mq[mon_b.ch].size() > 0) begin
            mon_r = mq[mon_b.ch].pop_front();
            act = 1; a_ch = mon_b.ch; a_rem = mon_r.len;
            a_src = mon_r.src; a_dst = mon_r.dst;
          end
        end
        if (act) begin
          check("mon_ch", mon_b.ch, a_ch);
          check("mon_len", mon_b.len, (a_rem > MAX_BURST) ? MAX_BURST : a_rem);
          check("mon_src", mon_b.src, a_src);
          check("mon_dst", mon_b.dst, a_dst);
          check("mon_last", mon_b.last, int'(a_rem <= MAX_BURST));
          if (a_rem <= MAX_BURST) act = 0;
          else begin
            a_rem -= MAX_BURST;
            a_src = (a_src + MAX_BURST) % 256;
            a_dst = (a_dst + MAX_BURST) % 256;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int ch, input int len, input int src, input int dst);
    int k = 0;
    in_valid[ch] = 1'b1;
    in_length[ch*LEN_W +: LEN_W] = LEN_W'(len);
    in_source[ch*ADDR_W +: ADDR_W] = ADDR_W'(src);
    in_destination[ch*ADDR_W +: ADDR_W] = ADDR_W'(dst);
    while (!in_ready[ch] && k < 50) begin step(); k++; end
    if (k == 50) check("send_timeout", 0, 1);
    step();
    in_valid[ch] = 1'b0;
  endtask

  task automatic wait_bursts(input int n, input string name);
    int k = 0;
    while (cap.size() < n && k < 100) begin step(); k++; end
    check(name, int'(cap.size() >= n), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2; nrst = 1'b0;
    #10; nrst = 1'b1;
    step();
  endtask

  int d0, pend;

  initial begin
    tbl[0] = '{0,  3, 'h10, 'h80, 1, 3, 3, 'h10, 'h80, 0};
    tbl[1] = '{1, 11, 'hF8, 'h20, 3, 4, 3, 'h00, 'h28, 0};
    tbl[2] = '{2,  4, 'h30, 'h40, 1, 4, 4, 'h30, 'h40, 0};
    tbl[3] = '{3,  5, 'hFE, 'h10, 2, 4, 1, 'h02, 'h14, 0};
    tbl[4] = '{0, 15, 'h00, 'hF0, 4, 4, 3, 'h0C, 'hFC, 0};
    tbl[5] = '{1,  0, 'h11, 'h22, 0, 0, 0, 0,     0,     1};
    tbl[6] = '{2,  8, 'hA0, 'hB0, 2, 4, 4, 'hA4, 'hB4, 0};
    tbl[7] = '{3,  1, 'hFF, 'hFF, 1, 1, 1, 'hFF, 'hFF, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_length", int'(out_length), 0);
    check("rst_out_source", int'(out_source), 0);
    check("rst_out_dest", int'(out_destination), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    check("rst_in_ready", int'(in_ready), 15);
    nrst = 1'b1;
    step();

    // Single request latency and fields
    out_ready = 1'b1;
    cap.delete();
    in_valid[0] = 1'b1;
    in_length[3:0] = 4'd3; in_source[7:0] = 8'h10; in_destination[7:0] = 8'h80;
    check("t1_in_ready", int'(in_ready[0]), 1);
    step();
    in_valid[0] = 1'b0;
    check("t1_valid_k", int'(out_valid), 0);
    step();
    check("t1_valid_k1", int'(out_valid), 1);
    check("t1_len", int'(out_length), 3);
    check("t1_src", int'(out_source), 'h10);
    check("t1_dst", int'(out_destination), 'h80);
    check("t1_ch", int'(out_ch), 0);
    check("t1_last", int'(out_last), 1);
    check("t1_drop", int'(drop_cnt), 0);
    step();
    check("t1_idle", int'(out_valid), 0);

    // Table of single requests, out_ready held high
    for (int i = 0; i < 8; i++) begin
      d0 = int'(drop_cnt);
      cap.delete();
      send(tbl[i].ch, tbl[i].len, tbl[i].src, tbl[i].dst);
      if (tbl[i].n > 0) wait_bursts(tbl[i].n, "tbl_wait");
      else repeat (4) step();
      step();
      check("tbl_nbursts", cap.size(), tbl[i].n);
      check("tbl_drop", int'(drop_cnt) - d0, tbl[i].drops);
      if (tbl[i].n > 0 && cap.size() == tbl[i].n) begin
        check("tbl_first_len", cap[0].len, tbl[i].first_len);
        check("tbl_last_len", cap[cap.size()-1].len, tbl[i].last_len);
        check("tbl_last_src", cap[cap.size()-1].src, tbl[i].last_src);
        check("tbl_last_dst", cap[cap.size()-1].dst, tbl[i].last_dst);
        check("tbl_last_flag", cap[cap.size()-1].last, 1);
        check("tbl_ch", cap[cap.size()-1].ch, tbl[i].ch);
      end
    end

    // Round-robin from reset: ch0..ch3 back to back, then ch0 again
    do_reset();
    out_ready = 1'b1;
    cap.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      in_valid[c] = 1'b1;
      in_length[c*LEN_W +: LEN_W] = 4'd1;
      in_source[c*ADDR_W +: ADDR_W] = ADDR_W'(16 * c);
      in_destination[c*ADDR_W +: ADDR_W] = ADDR_W'(16 * c + 8);
    end
    step();
    in_valid = 4'b0001;
    in_source[7:0] = 8'h50;
    step();
    in_valid = '0;
    wait_bursts(5, "t3_wait");
    if (cap.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t3_order", cap[i].ch, i % 4);
        check("t3_no_bubble", cap[i].cyc - cap[0].cyc, i);
      end
      check("t3_second_src", cap[4].src, 'h50);
    end
    step();

    // Zero-length requests are dropped
    cap.delete();
    for (int i = 0; i < 3; i++) send(3, 0, 'h33, 'h44);
    repeat (4) step();
    check("t5_drop_cnt", int'(drop_cnt), 3);
    check("t5_no_issue", cap.size(), 0);
    check("t5_idle", int'(out_valid), 0);

    // Stall with a full FIFO on ch2
    out_ready = 1'b0;
    cap.delete();
    for (int k = 0; k < 5; k++) begin
      in_valid[2] = 1'b1;
      in_length[11:8] = LEN_W'(1 + k % 4);
      in_source[23:16] = ADDR_W'('h40 + k);
      in_destination[23:16] = ADDR_W'('h60 + k);
      check("t4_ready", int'(in_ready[2]), 1);
      step();
    end
    in_valid[2] = 1'b0;
    check("t4_full", int'(in_ready[2]), 0);
    for (int k = 0; k < 3; k++) begin
      check("t4_stall_valid", int'(out_valid), 1);
      check("t4_stall_src", int'(out_source), 'h40);
      check("t4_stall_len", int'(out_length), 1);
      check("t4_stall_dst", int'(out_destination), 'h60);
      step();
    end
    out_ready = 1'b1;
    wait_bursts(5, "t4_wait");
    if (cap.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t4_order_src", cap[i].src, 'h40 + i);
        check("t4_order_ch", cap[i].ch, 2);
      end
    end
    step();
    check("t4_ready_back", int'(in_ready[2]), 1);

    // Reset in the middle of a split request
    cap.delete();
    send(0, 12, 0, 0);
    wait_bursts(1, "t6_wait");
    check("t6_mid_valid", int'(out_valid), 1);
    #1; nrst = 1'b0;
    #1;
    check("t6_async_valid", int'(out_valid), 0);
    check("t6_async_ready", int'(in_ready), 15);
    #10; nrst = 1'b1;
    repeat (10) step();
    check("t6_no_residual", cap.size(), 0);
    check("t6_idle", int'(out_valid), 0);
    check("t6_ready", int'(in_ready), 15);

    // Random traffic against the queue model
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        in_valid[c] = 1'($urandom_range(0, 1));
        in_length[c*LEN_W +: LEN_W] = ($urandom_range(0, 3) == 0) ? 4'd0
                                      : LEN_W'($urandom_range(1, 15));
        in_source[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 255));
        in_destination[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    pend = 1;
    for (int k = 0; k < 400 && pend != 0; k++) begin
      step();
      pend = int'(out_valid) + int'(act);
      for (int c = 0; c < NUM_CH; c++) pend += mq[c].size();
    end
    check("rnd_drained", pend, 0);
    check("rnd_drop_cnt", int'(drop_cnt), drop_model);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
